// File: rtl/riscv_pkg.sv
// Shared constants and state type for the RISC-V boot/run sequencer.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   // ecall is the SYSTEM opcode with every other field zero
   localparam logic [XLEN-1:0] ECALL_INSTR = {25'd0, OPC_SYSTEM};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_END
   } run_state_t;

endpackage

// File: rtl/riscv_load_ptr.sv
// Instruction-memory write pointer: word address, last-slot flag and image word count.
module riscv_load_ptr #(
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] ptr,
   output logic              last_slot,
   output logic [ADDR_W:0]   words_loaded
);

   assign last_slot = (ptr == ADDR_W'(IMEM_DEPTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= '0;
         words_loaded <= '0;
      end else if (clear) begin
         ptr          <= '0;
         words_loaded <= '0;
      end else if (advance) begin
         ptr          <= ptr + 1'b1;
         words_loaded <= words_loaded + 1'b1;
      end
   end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Boot/run sequencer: streams an image into IMEM, then runs the core until ecall.
// Optional cycle-budget watchdog enabled by defining RUN_WATCHDOG_EN.
module riscv_run_ctrl
   import riscv_pkg::*;
#(
   parameter int              IMEM_DEPTH = 256,
   parameter int              ADDR_W     = 8,
   parameter logic [XLEN-1:0] HALT_INSTR = ECALL_INSTR,
   parameter int              MAX_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [XLEN-1:0]   load_data,
   input  logic              load_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [XLEN-1:0]   imem_wdata,
   output logic              core_rst,
   input  logic [XLEN-1:0]   core_instr,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded,
   output logic [31:0]       cycles_run
);

`ifdef RUN_WATCHDOG_EN
   localparam bit WATCHDOG = 1'b1;
`else
   localparam bit WATCHDOG = 1'b0;
`endif

   run_state_t        state, state_next;
   logic              drain;
   logic              handshake, start_seq, overflow, halt_hit, expire, last_slot;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       cycles_inc;

   // drain marks the cycle the final image word is being written; no new word is taken
   assign load_ready = (state == ST_LOAD) && !drain;
   assign busy       = (state == ST_LOAD) || (state == ST_RUN);
   assign core_rst   = (state != ST_RUN);
   assign handshake  = load_valid && load_ready;
   assign start_seq  = start && ((state == ST_IDLE) || (state == ST_END));
   assign overflow   = handshake && !load_last && last_slot;
   assign halt_hit   = (state == ST_RUN) && (core_instr == HALT_INSTR);
   assign cycles_inc = (cycles_run == 32'hFFFF_FFFF) ? cycles_run : cycles_run + 32'd1;
   assign expire     = WATCHDOG && (state == ST_RUN) && (cycles_inc == 32'(MAX_CYCLES));

   riscv_load_ptr #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_load_ptr (
      .clk          (clk),
      .rst          (rst),
      .clear        (start_seq),
      .advance      (handshake),
      .ptr          (ptr),
      .last_slot    (last_slot),
      .words_loaded (words_loaded)
   );

   // NOTE: next state is defaulted first so no path through the case can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_END: if (start) state_next = ST_LOAD;
         ST_LOAD: begin
            if (drain)         state_next = ST_RUN;
            else if (overflow) state_next = ST_END;
         end
         ST_RUN: if (halt_hit || expire) state_next = ST_END;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         drain      <= 1'b0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         cycles_run <= '0;
      end else begin
         state   <= state_next;
         drain   <= handshake && load_last;
         imem_we <= handshake;
         if (handshake) begin
            imem_waddr <= ptr;
            imem_wdata <= load_data;
         end
         if (start_seq) begin
            done       <= 1'b0;
            error      <= 1'b0;
            cycles_run <= '0;
         end else begin
            if (halt_hit) done <= 1'b1;
            // a halt on the expiry cycle wins over the watchdog
            if (overflow || (expire && !halt_hit)) error <= 1'b1;
            if (state == ST_RUN) cycles_run <= cycles_inc;
         end
      end
   end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl with a small IMEM/core stand-in and a cycle-level reference model.
module tb_riscv_run_ctrl;

   localparam int          DEPTH = 8;
   localparam int          AW    = 3;
   localparam int          MAXC  = 16;
   localparam logic [31:0] HALT  = 32'h0000_0073;
`ifdef RUN_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_last = 1'b0;
   logic [31:0]   load_data = '0;
   logic          load_ready, imem_we, core_rst, busy, done, error;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata, core_instr, cycles_run;
   logic [AW:0]   words_loaded;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   riscv_run_ctrl #(
      .IMEM_DEPTH (DEPTH),
      .ADDR_W     (AW),
      .HALT_INSTR (HALT),
      .MAX_CYCLES (MAXC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .load_last    (load_last),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .core_instr   (core_instr),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded),
      .cycles_run   (cycles_run)
   );

   // Instruction memory plus a core that fetches sequentially from 0 once released
   logic [31:0]   mem [DEPTH] = '{default: 32'h0};
   logic [AW-1:0] pc = '0;
   always @(posedge clk) begin
      if (imem_we) mem[imem_waddr] <= imem_wdata;
      pc <= core_rst ? '0 : pc + 1'b1;
   end
   assign core_instr = mem[pc];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 loading, 2 running, 3 ended
   int          m_phase, m_ptr, m_words, m_waddr;
   bit          m_drain, m_we, m_done, m_err;
   logic [31:0] m_wdata, m_cycles;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_ptr = 0; m_words = 0; m_waddr = 0;
         m_drain = 0; m_we = 0; m_done = 0; m_err = 0;
         m_wdata = '0; m_cycles = '0;
      end else begin
         m_we = 0;
         case (m_phase)
            0, 3: if (start) begin
               m_phase = 1; m_done = 0; m_err = 0;
               m_words = 0; m_cycles = '0; m_ptr = 0; m_drain = 0;
            end
            1: if (m_drain) begin
               m_drain = 0;
               m_phase = 2;
            end else if (load_valid) begin
               m_we = 1; m_waddr = m_ptr; m_wdata = load_data; m_words++;
               if (load_last) m_drain = 1;
               else if (m_ptr == DEPTH - 1) begin
                  m_err = 1;
                  m_phase = 3;
               end
               m_ptr = (m_ptr + 1) % DEPTH;
            end
            2: begin
               if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
               if (core_instr == HALT) begin
                  m_done = 1;
                  m_phase = 3;
               end else if (WD && m_cycles == MAXC) begin
                  m_err = 1;
                  m_phase = 3;
               end
            end
            default: ;
         endcase
      end
   end

   // Per-cycle compare plus write/core-release monitors
   int wr_addr_q[$];
   int wr_cyc_q[$];
   int cyc = 0;
   int run_start_cyc = -1;
   int core_low_cnt = 0;
   bit core_rst_prev = 1'b1;

   always @(negedge clk) begin
      check("load_ready",   load_ready,   (m_phase == 1) && !m_drain);
      check("imem_we",      imem_we,      m_we);
      check("imem_waddr",   imem_waddr,   m_waddr);
      check("imem_wdata",   imem_wdata,   m_wdata);
      check("core_rst",     core_rst,     m_phase != 2);
      check("busy",         busy,         (m_phase == 1) || (m_phase == 2));
      check("done",         done,         m_done);
      check("error",        error,        m_err);
      check("words_loaded", words_loaded, m_words);
      check("cycles_run",   cycles_run,   m_cycles);
      cyc++;
      if (imem_we) begin
         wr_addr_q.push_back(int'(imem_waddr));
         wr_cyc_q.push_back(cyc);
      end
      if (!core_rst && core_rst_prev) run_start_cyc = cyc;
      if (!core_rst) core_low_cnt++;
      core_rst_prev = core_rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_image(input logic [31:0] w [8], input int n, input bit mark_last,
                             input bit toggle);
      for (int i = 0; i < n; i++) begin
         bit taken;
         taken      = 1'b0;
         load_valid = 1'b1;
         load_data  = w[i];
         load_last  = mark_last && (i == n - 1);
         for (int t = 0; t < 50 && !taken; t++) begin
            taken = load_ready;
            tick();
         end
         check("word_accepted", taken, 1'b1);
         load_valid = 1'b0;
         load_last  = 1'b0;
         if (toggle && i < n - 1) tick();
      end
   endtask

   task automatic wait_end(input string name);
      for (int i = 0; i < 200 && busy; i++) tick();
      check({name, "_ended"}, busy, 1'b0);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_load_ready"}, load_ready,   1'b0);
      check({name, "_imem_we"},    imem_we,      1'b0);
      check({name, "_imem_waddr"}, imem_waddr,   0);
      check({name, "_imem_wdata"}, imem_wdata,   0);
      check({name, "_core_rst"},   core_rst,     1'b1);
      check({name, "_busy"},       busy,         1'b0);
      check({name, "_done"},       done,         1'b0);
      check({name, "_error"},      error,        1'b0);
      check({name, "_words"},      words_loaded, 0);
      check({name, "_cycles"},     cycles_run,   0);
   endtask

   initial begin
      logic [31:0] img_a [8];
      logic [31:0] img_b [8];
      logic [31:0] img_e [8];
      int base;
      int low_base;

      // add x3,x1,x2 ; sub x3,x1,x2 ; or x3,x1,x2 ; ecall
      img_a = '{32'h002081B3, 32'h402081B3, 32'h0020E1B3, HALT, 0, 0, 0, 0};
      img_b = '{HALT, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 8; i++) img_e[i] = 32'h1000_0000 + i;

      #1 rst = 1'b1;
      tick(); tick();
      check_reset_values("por");
      rst = 1'b0;
      tick();

      // 4-word image, valid held high
      base = wr_addr_q.size();
      pulse_start();
      send_image(img_a, 4, 1'b1, 1'b0);
      wait_end("a");
      check("a_done", done, 1'b1);
      check("a_error", error, 1'b0);
      check("a_cycles", cycles_run, 4);
      check("a_model_cycles", m_cycles, 4);
      check("a_words", words_loaded, 4);
      check("a_core_rst", core_rst, 1'b1);
      check("a_nwrites", wr_addr_q.size() - base, 4);
      for (int i = 0; i < 4; i++) check("a_waddr", wr_addr_q[base + i], i);
      check("a_run_after_write", run_start_cyc - wr_cyc_q[$], 1);

      // restart after done with a single ecall word
      pulse_start();
      check("b_done_cleared", done, 1'b0);
      check("b_busy", busy, 1'b1);
      check("b_words_cleared", words_loaded, 0);
      send_image(img_b, 1, 1'b1, 1'b0);
      wait_end("b");
      check("b_done", done, 1'b1);
      check("b_cycles", cycles_run, 1);
      check("b_words", words_loaded, 1);

      // valid toggling 1/0: writes every other cycle, contiguous addresses
      base = wr_addr_q.size();
      pulse_start();
      send_image(img_a, 4, 1'b1, 1'b1);
      wait_end("c");
      check("c_nwrites", wr_addr_q.size() - base, 4);
      for (int i = 0; i < 4; i++) check("c_waddr", wr_addr_q[base + i], i);
      for (int i = 0; i < 3; i++)
         check("c_write_spacing", wr_cyc_q[base + i + 1] - wr_cyc_q[base + i], 2);
      check("c_done", done, 1'b1);
      check("c_cycles", cycles_run, 4);

      // reset in the middle of a load
      pulse_start();
      send_image(img_e, 3, 1'b0, 1'b0);
      check("d_words_before_reset", words_loaded, 3);
      rst = 1'b1;
      tick();
      check_reset_values("d");
      rst = 1'b0;
      tick();

      // image overflows the 8-word memory without a last marker
      base     = wr_addr_q.size();
      low_base = core_low_cnt;
      pulse_start();
      send_image(img_e, 8, 1'b0, 1'b0);
      wait_end("e");
      tick();
      check("e_error", error, 1'b1);
      check("e_done", done, 1'b0);
      check("e_words", words_loaded, 8);
      check("e_nwrites", wr_addr_q.size() - base, 8);
      check("e_last_waddr", wr_addr_q[$], 7);
      check("e_core_released", core_low_cnt - low_base, 0);
      check("e_cycles", cycles_run, 0);

`ifdef RUN_WATCHDOG_EN
      // no ecall anywhere in memory: the budget ends the run
      img_a[3] = 32'h002081B3;
      pulse_start();
      send_image(img_a, 4, 1'b1, 1'b0);
      wait_end("f");
      check("f_error", error, 1'b1);
      check("f_done", done, 1'b0);
      check("f_cycles", cycles_run, 16);
      repeat (5) tick();
      check("f_cycles_hold", cycles_run, 16);
      check("f_model_cycles", m_cycles, 16);
      check("f_core_rst", core_rst, 1'b1);
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
